// File: rtl/mips_data_memory.sv
// Data memory responder for the multicycle MIPS core: preload channel in LOAD, processor port in RUN.
// Optional write protection of the low PROT_WORDS words is enabled by defining MEM_WRITE_PROTECT_EN.
module mips_data_memory #(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          CNT_W       = 16,
  parameter int          PROT_WORDS  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [31:0]      writedata,
  output logic [31:0]      memdata,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  input  logic [31:0]      ld_data,
  output logic             ld_ready,
  input  logic             ld_done,
  output logic             busy,
  output logic             err_misalign,
  output logic             err_range,
  output logic             err_wprot,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);

  localparam int               IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0]      BASE_W  = ADDR_BASE[31:2];
  localparam logic [29:0]      DEPTH_L = 30'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {LOAD, RUN} state_t;

  state_t state, state_next;

  logic [31:0] mem [DEPTH_WORDS];

  logic [29:0]      off, ld_off;
  logic [IDX_W-1:0] idx, ld_idx;
  logic             in_range, ld_in_range;
  logic             misalign;
  logic             prot_hit;
  logic             acc_rd, acc_wr, ld_we;

  // Index math in word units; a byte address below the base wraps to a huge offset and fails the range check anyway.
  assign off         = addr[31:2] - BASE_W;
  assign ld_off      = ld_addr[31:2] - BASE_W;
  assign in_range    = (addr[31:2] >= BASE_W) && (off < DEPTH_L);
  assign ld_in_range = (ld_addr[31:2] >= BASE_W) && (ld_off < DEPTH_L);
  assign idx         = off[IDX_W-1:0];
  assign ld_idx      = ld_off[IDX_W-1:0];
  assign misalign    = (addr[1:0] != 2'b00);

  logic unused_bits;
  assign unused_bits = ^{off[29:IDX_W], ld_off[29:IDX_W], ld_addr[1:0]};

`ifdef MEM_WRITE_PROTECT_EN
  assign prot_hit = (off < 30'(PROT_WORDS));
`else
  logic unused_prot;
  assign unused_prot = ^PROT_WORDS;
  assign prot_hit    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    ld_ready   = 1'b0;
    acc_rd     = 1'b0;
    acc_wr     = 1'b0;
    ld_we      = 1'b0;
    if (state == LOAD) begin
      busy     = 1'b1;
      ld_ready = 1'b1;
      ld_we    = ld_valid && ld_in_range;
      if (ld_done) state_next = RUN;
    end else begin
      acc_rd = memread;
      acc_wr = memwrite;
    end
  end

  // RAM has no reset so preloaded contents survive a core reset.
  always_ff @(posedge clk) begin
    if (ld_we)
      mem[ld_idx] <= ld_data;
    else if (acc_wr && in_range && !prot_hit)
      mem[idx] <= writedata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memdata      <= 32'h0;
      err_misalign <= 1'b0;
      err_range    <= 1'b0;
      err_wprot    <= 1'b0;
      rd_count     <= '0;
      wr_count     <= '0;
    end else begin
      if (acc_rd) memdata <= in_range ? mem[idx] : 32'h0;
      if ((acc_rd || acc_wr) && misalign)  err_misalign <= 1'b1;
      if ((acc_rd || acc_wr) && !in_range) err_range    <= 1'b1;
      if (acc_wr && in_range && prot_hit)  err_wprot    <= 1'b1;
      if (acc_rd && rd_count != CNT_MAX) rd_count <= rd_count + 1'b1;
      if (acc_wr && wr_count != CNT_MAX) wr_count <= wr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_data_memory.sv
// Directed bench for mips_data_memory: preload, processor access table, reset retention, counter saturation.
module tb_mips_data_memory;

  logic        clk, reset;
  logic [31:0] addr, writedata, memdata, ld_addr, ld_data;
  logic        memread, memwrite, ld_valid, ld_ready, ld_done, busy;
  logic        err_misalign, err_range, err_wprot;
  logic [15:0] rd_count, wr_count;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MEM_WRITE_PROTECT_EN
  localparam logic        WP     = 1'b1;
  localparam logic [31:0] W1_EXP = 32'h2003000c;
`else
  localparam logic        WP     = 1'b0;
  localparam logic [31:0] W1_EXP = 32'hdeadbeef;
`endif

  mips_data_memory dut (
    .clk(clk), .reset(reset), .addr(addr), .memread(memread), .memwrite(memwrite),
    .writedata(writedata), .memdata(memdata), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_ready(ld_ready), .ld_done(ld_done), .busy(busy),
    .err_misalign(err_misalign), .err_range(err_range), .err_wprot(err_wprot),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] md;
    logic [15:0] rc;
    logic [15:0] wc;
    logic [2:0]  err;   // {misalign, range, wprot}
  } vec_t;

  vec_t vecs[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d, input logic done);
    ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_done = done;
    step();
    ld_valid = 1'b0; ld_done = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'h08,  32'h0,        32'h2067fff7, 16'd1,  16'd0, 3'b000};
    vecs[1]  = '{1'b0, 1'b1, 32'h50,  32'h7,        32'h2067fff7, 16'd1,  16'd1, 3'b000};
    vecs[2]  = '{1'b1, 1'b0, 32'h50,  32'h0,        32'h00000007, 16'd2,  16'd1, 3'b000};
    vecs[3]  = '{1'b1, 1'b1, 32'h54,  32'h22222222, 32'h11111111, 16'd3,  16'd2, 3'b000};
    vecs[4]  = '{1'b1, 1'b0, 32'h54,  32'h0,        32'h22222222, 16'd4,  16'd2, 3'b000};
    vecs[5]  = '{1'b1, 1'b0, 32'h60,  32'h0,        32'h33333333, 16'd5,  16'd2, 3'b000};
    vecs[6]  = '{1'b1, 1'b0, 32'h00,  32'h0,        32'h20020005, 16'd6,  16'd2, 3'b000};
    vecs[7]  = '{1'b0, 1'b0, 32'h08,  32'h0,        32'h20020005, 16'd6,  16'd2, 3'b000};
    vecs[8]  = '{1'b0, 1'b1, 32'h04,  32'hdeadbeef, 32'h20020005, 16'd6,  16'd3, {2'b00, WP}};
    vecs[9]  = '{1'b1, 1'b0, 32'h04,  32'h0,        W1_EXP,       16'd7,  16'd3, {2'b00, WP}};
    vecs[10] = '{1'b1, 1'b0, 32'h42,  32'h0,        32'ha5a5a5a5, 16'd8,  16'd3, {2'b10, WP}};
    vecs[11] = '{1'b0, 1'b1, 32'h400, 32'h99999999, 32'ha5a5a5a5, 16'd8,  16'd4, {2'b11, WP}};
    vecs[12] = '{1'b1, 1'b0, 32'h400, 32'h0,        32'h00000000, 16'd9,  16'd4, {2'b11, WP}};
    vecs[13] = '{1'b1, 1'b0, 32'hfc,  32'h0,        32'h0f0f0f0f, 16'd10, 16'd4, {2'b11, WP}};
    vecs[14] = '{1'b1, 1'b0, 32'h100, 32'h0,        32'h00000000, 16'd11, 16'd4, {2'b11, WP}};
    vecs[15] = '{1'b1, 1'b0, 32'h00,  32'h0,        32'h20020005, 16'd12, 16'd4, {2'b11, WP}};

    reset = 1'b1; addr = '0; memread = 1'b0; memwrite = 1'b0; writedata = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
    step(); step();
    check("rst_memdata", memdata, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd1);
    check("rst_ld_ready", {31'b0, ld_ready}, 32'd1);
    check("rst_flags", {29'b0, err_misalign, err_range, err_wprot}, 32'd0);
    check("rst_counts", {rd_count, wr_count}, 32'd0);
    reset = 1'b0;

    // Processor requests during LOAD must be ignored.
    memread = 1'b1; memwrite = 1'b1; addr = 32'h401; writedata = 32'hffffffff;
    preload(32'h00,  32'h20020005, 1'b0);
    preload(32'h04,  32'h2003000c, 1'b0);
    memread = 1'b0; memwrite = 1'b0;
    preload(32'h08,  32'h2067fff7, 1'b0);
    preload(32'h0c,  32'h00e22025, 1'b0);
    preload(32'h40,  32'ha5a5a5a5, 1'b0);
    preload(32'h54,  32'h11111111, 1'b0);
    preload(32'hfc,  32'h0f0f0f0f, 1'b0);
    preload(32'h400, 32'h12345678, 1'b0);
    check("load_busy", {31'b0, busy}, 32'd1);
    check("load_ignored", {memdata[15:0], rd_count | wr_count}, 32'd0);
    check("load_flags", {29'b0, err_misalign, err_range, err_wprot}, 32'd0);
    preload(32'h60,  32'h33333333, 1'b1);
    check("run_busy", {31'b0, busy}, 32'd0);
    check("run_ld_ready", {31'b0, ld_ready}, 32'd0);

    // ld_* must be ignored in RUN.
    ld_valid = 1'b1; ld_addr = 32'h08; ld_data = 32'hbad0bad0; ld_done = 1'b1;

    for (int i = 0; i < 16; i++) begin
      memread = vecs[i].rd; memwrite = vecs[i].wr; addr = vecs[i].a; writedata = vecs[i].wd;
      step();
      check($sformatf("vec%0d_memdata", i), memdata, vecs[i].md);
      check($sformatf("vec%0d_rd_count", i), {16'b0, rd_count}, {16'b0, vecs[i].rc});
      check($sformatf("vec%0d_wr_count", i), {16'b0, wr_count}, {16'b0, vecs[i].wc});
      check($sformatf("vec%0d_flags", i), {29'b0, err_misalign, err_range, err_wprot}, {29'b0, vecs[i].err});
    end
    ld_valid = 1'b0; ld_done = 1'b0;
    memread = 1'b1; memwrite = 1'b0; addr = 32'h08;
    step();
    check("run_ld_ignored", memdata, 32'h2067fff7);
    memread = 1'b0;

    // Asynchronous reset mid-RUN: state clears immediately, RAM is kept.
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 32'd1);
    check("mid_rst_memdata", memdata, 32'h0);
    check("mid_rst_counts", {rd_count, wr_count}, 32'd0);
    check("mid_rst_flags", {29'b0, err_misalign, err_range, err_wprot}, 32'd0);
    step();
    reset = 1'b0;
    ld_done = 1'b1;
    step();
    ld_done = 1'b0;
    check("rerun_busy", {31'b0, busy}, 32'd0);
    memread = 1'b1; addr = 32'h50;
    step();
    check("retained_0x50", memdata, 32'h00000007);
    check("retained_rd_count", {16'b0, rd_count}, 32'd1);

    // Saturation of both counters with simultaneous read/write.
    memwrite = 1'b1; writedata = 32'h7;
    for (int i = 0; i < 65540; i++) step();
    check("sat_rd_count", {16'b0, rd_count}, 32'd65535);
    check("sat_wr_count", {16'b0, wr_count}, 32'd65535);
    step();
    check("sat_hold", {rd_count, wr_count}, 32'hffffffff);
    memread = 1'b0; memwrite = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
